// File: rtl/store_commit_queue.sv
// Committed-store queue: buffers retired stores in order and drains them to the D$.
// It also flags loads whose page offset may alias a pending or incoming store.
module store_commit_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [63:0] paddr_i,
  input  logic [63:0] data_i,
  input  logic [7:0]  be_i,
  input  logic [1:0]  data_size_i,
  input  logic [11:0] page_offset_i,
  output logic        page_offset_matches_o,
  output logic        no_st_pending_o,
  output logic        req_o,
  input  logic        gnt_i,
  output logic [63:0] addr_o,
  output logic [63:0] wdata_o,
  output logic [7:0]  be_o,
  output logic [1:0]  size_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [63:0]      paddr_q [DEPTH];
  logic [63:0]      data_q  [DEPTH];
  logic [7:0]       be_q    [DEPTH];
  logic [1:0]       size_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic push;
  logic pop;
  logic match;
  logic unused_offset_bits;

  // Both ports use valid/ready semantics: a transfer happens in exactly the
  // cycle where the source's valid (valid_i / req_o) and the sink's
  // ready (ready_o / gnt_i) are both high; the source holds its payload
  // stable until that cycle.
  assign ready_o = (count_q != FULL_CNT);
  assign req_o   = (count_q != '0);
  assign push    = valid_i && ready_o;
  assign pop     = req_o && gnt_i;

  assign no_st_pending_o = (count_q == '0);

  assign addr_o  = paddr_q[rd_ptr_q];
  assign wdata_o = data_q[rd_ptr_q];
  assign be_o    = be_q[rd_ptr_q];
  assign size_o  = size_q[rd_ptr_q];

  // Byte offset inside a doubleword never disambiguates; only bits [11:3] compare.
  assign unused_offset_bits = ^page_offset_i[2:0];

  always_comb begin
    match = valid_i && (paddr_i[11:3] == page_offset_i[11:3]);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (paddr_q[i][11:3] == page_offset_i[11:3])) begin
        match = 1'b1;
      end
    end
  end

  assign page_offset_matches_o = match;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        paddr_q[i] <= '0;
        data_q[i]  <= '0;
        be_q[i]    <= '0;
        size_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        paddr_q[wr_ptr_q] <= paddr_i;
        data_q[wr_ptr_q]  <= data_i;
        be_q[wr_ptr_q]    <= be_i;
        size_q[wr_ptr_q]  <= data_size_i;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      // A pop and a push never hit the same slot: that needs empty (no pop) or full (no push).
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_store_commit_queue.sv
// Directed bench for store_commit_queue: hand-computed vectors plus an
// in-order issue scoreboard fed by the expected-address queue.
module tb_store_commit_queue;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [63:0] paddr_i;
  logic [63:0] data_i;
  logic [7:0]  be_i;
  logic [1:0]  data_size_i;
  logic [11:0] page_offset_i;
  logic        page_offset_matches_o;
  logic        no_st_pending_o;
  logic        req_o;
  logic        gnt_i;
  logic [63:0] addr_o;
  logic [63:0] wdata_o;
  logic [7:0]  be_o;
  logic [1:0]  size_o;

  int n_vec;
  int n_err;
  int n_issue;
  logic [63:0] exp_q[$];

  store_commit_queue #(.DEPTH(4)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .valid_i               (valid_i),
    .ready_o               (ready_o),
    .paddr_i               (paddr_i),
    .data_i                (data_i),
    .be_i                  (be_i),
    .data_size_i           (data_size_i),
    .page_offset_i         (page_offset_i),
    .page_offset_matches_o (page_offset_matches_o),
    .no_st_pending_o       (no_st_pending_o),
    .req_o                 (req_o),
    .gnt_i                 (gnt_i),
    .addr_o                (addr_o),
    .wdata_o               (wdata_o),
    .be_o                  (be_o),
    .size_o                (size_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: inputs only change just after posedge, so negedge sees the
  // handshake that the next posedge will act on
  always @(negedge clk_i) begin
    if (rst_ni && req_o && gnt_i) begin
      n_issue++;
      if (exp_q.size() == 0) begin
        check("issue_unexpected", 64'd1, 64'd0);
      end else begin
        check("issue_order", addr_o, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_one(input logic [63:0] addr, input logic [63:0] data);
    valid_i     = 1'b1;
    paddr_i     = addr;
    data_i      = data;
    be_i        = 8'hFF;
    data_size_i = 2'd3;
    tick();
    valid_i     = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_issue = 0;
    rst_ni = 1'b0; valid_i = 1'b0; gnt_i = 1'b0;
    paddr_i = '0; data_i = '0; be_i = '0; data_size_i = '0; page_offset_i = '0;
    repeat (2) tick();

    check("rst_ready", ready_o, 1);
    check("rst_req", req_o, 0);
    check("rst_nsp", no_st_pending_o, 1);
    check("rst_match", page_offset_matches_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_be", be_o, 0);
    check("rst_size", size_o, 0);
    rst_ni = 1'b1;
    tick();

    // single store, held while not granted, then one grant
    valid_i = 1'b1; paddr_i = 64'h8000_0010; data_i = 64'hDEAD_BEEF;
    be_i = 8'h0F; data_size_i = 2'd2;
    check("no_bypass_req", req_o, 0);
    tick();
    valid_i = 1'b0;
    exp_q.push_back(64'h8000_0010);
    check("single_req", req_o, 1);
    check("single_nsp", no_st_pending_o, 0);
    check("single_wdata", wdata_o, 64'hDEAD_BEEF);
    check("single_be", be_o, 8'h0F);
    check("single_size", size_o, 2);
    for (int i = 0; i < 5; i++) begin
      check("hold_req", req_o, 1);
      check("hold_addr", addr_o, 64'h8000_0010);
      tick();
    end
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    check("after_gnt_req", req_o, 0);
    check("after_gnt_nsp", no_st_pending_o, 1);

    // fill to DEPTH, a fifth push must be dropped
    for (int i = 0; i < 4; i++) begin
      push_one(64'hA000 + 64'(i * 8), 64'(i));
      exp_q.push_back(64'hA000 + 64'(i * 8));
    end
    check("full_ready", ready_o, 0);
    push_one(64'hBAD0, 64'h5);
    check("full_ignored_ready", ready_o, 0);
    check("full_head", addr_o, 64'hA000);
    gnt_i = 1'b1;
    repeat (4) tick();
    gnt_i = 1'b0;
    check("full_drained_req", req_o, 0);
    check("full_q_empty", 64'(exp_q.size()), 0);

    // full queue, push and grant together: only the pop happens
    for (int i = 0; i < 4; i++) begin
      push_one(64'hB000 + 64'(i * 8), 64'(i));
      exp_q.push_back(64'hB000 + 64'(i * 8));
    end
    valid_i = 1'b1; paddr_i = 64'hC000; gnt_i = 1'b1;
    tick();
    valid_i = 1'b0; gnt_i = 1'b0;
    check("pushpop_ready", ready_o, 1);
    check("pushpop_req", req_o, 1);
    check("pushpop_head", addr_o, 64'hB008);
    push_one(64'hB020, 64'h9);
    exp_q.push_back(64'hB020);
    check("pushpop_count3", ready_o, 0);
    gnt_i = 1'b1;
    repeat (4) tick();
    gnt_i = 1'b0;
    check("pushpop_drained", req_o, 0);
    check("pushpop_q_empty", 64'(exp_q.size()), 0);

    // continuous grant, ten back-to-back pushes wrap the pointers
    n_issue = 0;
    gnt_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_one(64'h1_0000 + 64'(i * 64'h100), 64'(i));
      exp_q.push_back(64'h1_0000 + 64'(i * 64'h100));
      check("stream_ready", ready_o, 1);
    end
    tick();
    gnt_i = 1'b0;
    check("stream_issued", 64'(n_issue), 10);
    check("stream_q_empty", 64'(exp_q.size()), 0);
    check("stream_req", req_o, 0);

    // page-offset disambiguation
    push_one(64'h1238, 64'h1);
    page_offset_i = 12'h23C;
    #1 check("match_pending", page_offset_matches_o, 1);
    page_offset_i = 12'h240;
    #1 check("nomatch_pending", page_offset_matches_o, 0);
    exp_q.push_back(64'h1238);
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    check("match_empty_idle", page_offset_matches_o, 0);
    valid_i = 1'b1; paddr_i = 64'h5240;
    #1 check("match_incoming", page_offset_matches_o, 1);
    tick();
    valid_i = 1'b0;
    exp_q.push_back(64'h5240);
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    page_offset_i = '0;

    // asynchronous reset mid-transfer with two pending entries
    push_one(64'hE000, 64'h1);
    push_one(64'hE008, 64'h2);
    check("prerst_req", req_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    check("arst_req", req_o, 0);
    check("arst_ready", ready_o, 1);
    check("arst_nsp", no_st_pending_o, 1);
    check("arst_addr", addr_o, 0);
    rst_ni = 1'b1;
    n_issue = 0;
    gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_req", req_o, 0);
    end
    gnt_i = 1'b0;
    check("postrst_issued", 64'(n_issue), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
